// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle RV32I main control FSM with memory handshake, timeout trap and retire counter
module mc_ctrl_fsm #(
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int ALL_BRANCHES    = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state_o,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_DECODE    = 4'd1,  S_EXEC_R    = 4'd2,  S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,  S_MEM_READ  = 4'd5,  S_MEM_WRITE = 4'd6,  S_MEM_WB    = 4'd7,
    S_ALU_WB    = 4'd8,  S_JAL       = 4'd9,  S_JALR_ADDR = 4'd10, S_JALR_JUMP = 4'd11,
    S_BRANCH    = 4'd12, S_LUI       = 4'd13, S_AUIPC     = 4'd14, S_TRAP      = 4'd15
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);

  state_t        state, next_state;
  logic [TW-1:0] tmo_cnt;
  logic          mem_wait, tmo_hit, illegal, retire;
  logic          br_legal, br_taken;

  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = (ALL_BRANCHES != 0) && lt;
      3'b101:  br_taken = (ALL_BRANCHES != 0) && !lt;
      3'b110:  br_taken = (ALL_BRANCHES != 0) && ltu;
      3'b111:  br_taken = (ALL_BRANCHES != 0) && !ltu;
      default: br_legal = 1'b0;
    endcase
  end

  // The limit cycle itself still accepts mem_ready; only a miss on it traps.
  assign mem_wait = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign tmo_hit  = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready && (tmo_cnt == TMO_LIMIT);

  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0110011:             next_state = S_EXEC_R;
          7'b0010011:             next_state = S_EXEC_I;
          7'b0000011, 7'b0100011: next_state = S_MEM_ADDR;
          7'b1100011:             next_state = S_BRANCH;
          7'b1101111:             next_state = S_JAL;
          7'b1100111:             if (funct3 == 3'b000) next_state = S_JALR_ADDR;
                                  else illegal = 1'b1;
          7'b0110111:             next_state = S_LUI;
          7'b0010111:             next_state = S_AUIPC;
          default:                illegal = 1'b1;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL, S_JALR_JUMP: next_state = S_ALU_WB;
      S_MEM_ADDR:  next_state = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_MEM_WB, S_ALU_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_JALR_ADDR: next_state = S_JALR_JUMP;
      S_BRANCH: begin
        if (br_legal) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default:     next_state = S_TRAP;
    endcase
    if (tmo_hit) next_state = S_TRAP;
    if (illegal) next_state = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_FETCH;
      tmo_cnt      <= '0;
      trap_cause   <= 2'b00;
      retire_count <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        tmo_cnt <= '0;
      else if (mem_wait && !mem_ready && (MEM_TIMEOUT != 0))
        tmo_cnt <= tmo_cnt + TW'(1);
      if ((next_state == S_TRAP) && (state != S_TRAP))
        trap_cause <= tmo_hit ? 2'b10 : 2'b01;
      if (retire)
        retire_count <= retire_count + CNT_W'(1);
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_EXEC_R: begin
          ALUSrcA = 2'b10;
          alu_op  = 2'b10;
        end
        S_EXEC_I: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_LUI: begin
          ALUSrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          alu_op  = 2'b10;
        end
        S_MEM_ADDR, S_JALR_ADDR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_MEM_WB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_ALU_WB:  RegWrite = 1'b1;
        S_JAL, S_JALR_JUMP: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          alu_op  = 2'b01;
          PCWrite = br_taken;
        end
        default: ;
      endcase
    end
  end

  assign trap          = rst && (state == S_TRAP);
  assign state_o       = state;
  assign instr_retired = rst && retire;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed bench for mc_ctrl_fsm, default instance (a) and reduced instance (b)
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  logic a_mem_req, a_pcw, a_adr, a_mw, a_irw, a_rw, a_trap, a_ret;
  logic [1:0] a_rs, a_sa, a_sb, a_op, a_cause;
  logic [3:0] a_state;
  logic [31:0] a_cnt;
  logic b_mem_req, b_pcw, b_adr, b_mw, b_irw, b_rw, b_trap, b_ret;
  logic [1:0] b_rs, b_sa, b_sb, b_op, b_cause;
  logic [3:0] b_state;
  logic [1:0] b_cnt;
  logic [13:0] a_ctl, b_ctl;

  int vecs = 0;
  int errs = 0;

  localparam logic [13:0] C_FETCH_RDY  = 14'b110010_10_00_10_00;
  localparam logic [13:0] C_FETCH_WAIT = 14'b100000_10_00_10_00;
  localparam logic [13:0] C_DECODE     = 14'b000000_00_01_01_00;
  localparam logic [13:0] C_EXEC_R     = 14'b000000_00_10_00_10;
  localparam logic [13:0] C_ALU_WB     = 14'b000001_00_00_00_00;
  localparam logic [13:0] C_ADDR       = 14'b000000_00_10_01_00;
  localparam logic [13:0] C_MEM_RD     = 14'b101000_00_00_00_00;
  localparam logic [13:0] C_MEM_WB     = 14'b000001_01_00_00_00;
  localparam logic [13:0] C_MEM_WR     = 14'b101100_00_00_00_00;
  localparam logic [13:0] C_JUMP       = 14'b010000_00_01_10_00;
  localparam logic [13:0] C_BR_T       = 14'b010000_00_10_00_01;
  localparam logic [13:0] C_BR_N       = 14'b000000_00_10_00_01;

  assign a_ctl = {a_mem_req, a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_op};
  assign b_ctl = {b_mem_req, b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_op};

  always #5 clk = ~clk;

  mc_ctrl_fsm u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw),
    .IRWrite(a_irw), .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
    .alu_op(a_op), .trap(a_trap), .trap_cause(a_cause), .state_o(a_state),
    .instr_retired(a_ret), .retire_count(a_cnt)
  );

  mc_ctrl_fsm #(.TRAP_ON_ILLEGAL(0), .ALL_BRANCHES(0), .MEM_TIMEOUT(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw),
    .IRWrite(b_irw), .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
    .alu_op(b_op), .trap(b_trap), .trap_cause(b_cause), .state_o(b_state),
    .instr_retired(b_ret), .retire_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves both instances in the first post-DECODE state.
  task automatic start_instr(input logic [6:0] op, input logic [2:0] f3);
    opcode    = op;
    funct3    = f3;
    mem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    vecs++; if ({a_ctl, a_state, a_trap, a_cause, a_ret} !== 21'd0) begin errs++; $display("FAIL reset_outs: got %h want 0", {a_ctl, a_state, a_trap, a_cause, a_ret}); end
    vecs++; if (a_cnt !== 32'd0 || b_cnt !== 2'd0) begin errs++; $display("FAIL reset_cnt: got a=%0d b=%0d want 0", a_cnt, b_cnt); end
    rst = 1'b1;
    #1;
    vecs++; if ({a_state, a_ctl} !== {4'd0, C_FETCH_RDY}) begin errs++; $display("FAIL reset_release: got %h want %h", {a_state, a_ctl}, {4'd0, C_FETCH_RDY}); end
  endtask

  task automatic test_add();
    opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b1;
    tick();
    vecs++; if ({a_state, a_ctl} !== {4'd1, C_DECODE}) begin errs++; $display("FAIL add_decode: got %h want %h", {a_state, a_ctl}, {4'd1, C_DECODE}); end
    tick();
    vecs++; if ({a_state, a_ctl} !== {4'd2, C_EXEC_R}) begin errs++; $display("FAIL add_exec: got %h want %h", {a_state, a_ctl}, {4'd2, C_EXEC_R}); end
    tick();
    vecs++; if ({a_state, a_ctl, a_ret} !== {4'd8, C_ALU_WB, 1'b1}) begin errs++; $display("FAIL add_wb: got %h want %h", {a_state, a_ctl, a_ret}, {4'd8, C_ALU_WB, 1'b1}); end
    tick();
    vecs++; if (a_state !== 4'd0 || a_cnt !== 32'd1 || b_cnt !== 2'd1) begin errs++; $display("FAIL add_retire: got st=%0d a=%0d b=%0d want 0/1/1", a_state, a_cnt, b_cnt); end
  endtask

  task automatic test_load();
    start_instr(7'b0000011, 3'b010);
    vecs++; if ({a_state, a_ctl} !== {4'd4, C_ADDR}) begin errs++; $display("FAIL lw_addr: got %h want %h", {a_state, a_ctl}, {4'd4, C_ADDR}); end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({a_state, a_ctl} !== {4'd5, C_MEM_RD}) begin errs++; $display("FAIL lw_wait%0d: got %h want %h", i, {a_state, a_ctl}, {4'd5, C_MEM_RD}); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    vecs++; if ({a_state, a_ctl} !== {4'd5, C_MEM_RD}) begin errs++; $display("FAIL lw_ready: got %h want %h", {a_state, a_ctl}, {4'd5, C_MEM_RD}); end
    tick();
    vecs++; if ({a_state, a_ctl, a_ret} !== {4'd7, C_MEM_WB, 1'b1}) begin errs++; $display("FAIL lw_wb: got %h want %h", {a_state, a_ctl, a_ret}, {4'd7, C_MEM_WB, 1'b1}); end
    tick();
    vecs++; if (a_cnt !== 32'd2 || b_cnt !== 2'd2) begin errs++; $display("FAIL lw_cnt: got a=%0d b=%0d want 2/2", a_cnt, b_cnt); end
  endtask

  task automatic test_branch();
    lt = 1'b1;
    start_instr(7'b1100011, 3'b100);
    vecs++; if ({a_state, a_ctl, a_ret} !== {4'd12, C_BR_T, 1'b1}) begin errs++; $display("FAIL blt_taken: got %h want %h", {a_state, a_ctl, a_ret}, {4'd12, C_BR_T, 1'b1}); end
    vecs++; if ({b_ctl, b_ret} !== {C_BR_N, 1'b1}) begin errs++; $display("FAIL blt_nobranches: got %h want %h", {b_ctl, b_ret}, {C_BR_N, 1'b1}); end
    tick();
    lt = 1'b0;
    start_instr(7'b1100011, 3'b100);
    vecs++; if (a_ctl !== C_BR_N) begin errs++; $display("FAIL blt_not: got %h want %h", a_ctl, C_BR_N); end
    tick();
    vecs++; if (a_cnt !== 32'd4 || b_cnt !== 2'd0) begin errs++; $display("FAIL br_cnt_wrap: got a=%0d b=%0d want 4/0", a_cnt, b_cnt); end
    ltu = 1'b0;
    start_instr(7'b1100011, 3'b111);
    vecs++; if ({a_ctl, b_ctl} !== {C_BR_T, C_BR_N}) begin errs++; $display("FAIL bgeu: got %h want %h", {a_ctl, b_ctl}, {C_BR_T, C_BR_N}); end
    tick();
  endtask

  task automatic test_jalr();
    start_instr(7'b1100111, 3'b000);
    vecs++; if ({a_state, a_ctl} !== {4'd10, C_ADDR}) begin errs++; $display("FAIL jalr_addr: got %h want %h", {a_state, a_ctl}, {4'd10, C_ADDR}); end
    tick();
    vecs++; if ({a_state, a_ctl} !== {4'd11, C_JUMP}) begin errs++; $display("FAIL jalr_jump: got %h want %h", {a_state, a_ctl}, {4'd11, C_JUMP}); end
    tick();
    vecs++; if ({a_state, a_ctl, a_ret} !== {4'd8, C_ALU_WB, 1'b1}) begin errs++; $display("FAIL jalr_wb: got %h want %h", {a_state, a_ctl, a_ret}, {4'd8, C_ALU_WB, 1'b1}); end
    tick();
    vecs++; if (a_cnt !== 32'd6 || b_cnt !== 2'd2) begin errs++; $display("FAIL jalr_cnt: got a=%0d b=%0d want 6/2", a_cnt, b_cnt); end
  endtask

  task automatic test_reset_mid_read();
    start_instr(7'b0000011, 3'b010);
    mem_ready = 1'b0;
    tick(); tick();
    #1;
    rst = 1'b0;
    #1;
    vecs++; if ({a_state, a_ctl, a_ret} !== 19'd0 || a_cnt !== 32'd0) begin errs++; $display("FAIL rst_mid_read: got %h cnt=%0d want 0", {a_state, a_ctl, a_ret}, a_cnt); end
    tick();
    rst = 1'b1;
    #1;
    vecs++; if ({a_state, a_ctl} !== {4'd0, C_FETCH_WAIT}) begin errs++; $display("FAIL rst_refetch: got %h want %h", {a_state, a_ctl}, {4'd0, C_FETCH_WAIT}); end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
    tick();
    vecs++; if ({b_state, b_ret} !== {4'd1, 1'b0}) begin errs++; $display("FAIL ill_decode_b: got %h want %h", {b_state, b_ret}, {4'd1, 1'b0}); end
    tick();
    vecs++; if ({a_state, a_trap, a_cause, a_ctl} !== {4'd15, 1'b1, 2'b01, 14'd0}) begin errs++; $display("FAIL ill_trap_a: got %h want %h", {a_state, a_trap, a_cause, a_ctl}, {4'd15, 1'b1, 2'b01, 14'd0}); end
    vecs++; if ({b_state, b_trap} !== {4'd0, 1'b0}) begin errs++; $display("FAIL ill_nop_b: got %h want 0", {b_state, b_trap}); end
    opcode = 7'b0110011;
    repeat (3) tick();
    vecs++; if ({a_state, a_trap, a_cause} !== {4'd15, 1'b1, 2'b01}) begin errs++; $display("FAIL ill_sticky: got %h want %h", {a_state, a_trap, a_cause}, {4'd15, 1'b1, 2'b01}); end
    vecs++; if (b_cnt !== 2'd0) begin errs++; $display("FAIL ill_b_cnt: got %0d want 0", b_cnt); end
    pulse_reset();
    #1;
    vecs++; if ({a_state, a_trap, a_cause} !== 7'd0) begin errs++; $display("FAIL ill_clear: got %h want 0", {a_state, a_trap, a_cause}); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    start_instr(7'b0100011, 3'b010);
    mem_ready = 1'b0;
    tick();
    vecs++; if ({b_state, b_ctl} !== {4'd6, C_MEM_WR}) begin errs++; $display("FAIL sw_write: got %h want %h", {b_state, b_ctl}, {4'd6, C_MEM_WR}); end
    repeat (4) tick();
    vecs++; if (b_state !== 4'd6) begin errs++; $display("FAIL sw_limit_hold: got %0d want 6", b_state); end
    tick();
    vecs++; if ({b_state, b_trap, b_cause} !== {4'd15, 1'b1, 2'b10}) begin errs++; $display("FAIL sw_timeout: got %h want %h", {b_state, b_trap, b_cause}, {4'd15, 1'b1, 2'b10}); end
    vecs++; if (a_state !== 4'd6) begin errs++; $display("FAIL sw_a_waiting: got %0d want 6", a_state); end
    pulse_reset();
    start_instr(7'b0100011, 3'b010);
    mem_ready = 1'b0;
    tick();
    repeat (4) tick();
    mem_ready = 1'b1;
    #1;
    vecs++; if ({b_state, b_ret, b_mw} !== {4'd6, 1'b1, 1'b1}) begin errs++; $display("FAIL sw_limit_ready: got %h want %h", {b_state, b_ret, b_mw}, {4'd6, 1'b1, 1'b1}); end
    tick();
    vecs++; if ({b_state, b_trap, b_cnt} !== {4'd0, 1'b0, 2'd1} || a_cnt !== 32'd1) begin errs++; $display("FAIL sw_limit_done: got %h a=%0d want %h a=1", {b_state, b_trap, b_cnt}, a_cnt, {4'd0, 1'b0, 2'd1}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_jalr();
    test_reset_mid_read();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised successor to the multicycle RV32I main control FSM. It covers all six conditional branches, JAL/JALR, LUI/AUIPC, loads and stores, and stalls on a memory ready handshake with a configurable timeout. Illegal instructions and memory timeouts drive a sticky trap state. A retired-instruction counter is included. It drives the existing multicycle datapath (PC, IR, ALUOut, Data registers, result mux).

Parameters:
TRAP_ON_ILLEGAL, 1, 1: undefined opcode/funct3 enters TRAP; 0: instruction treated as NOP (back to FETCH).
ALL_BRANCHES, 1, 1: BLT/BGE/BLTU/BGEU supported; 0: only BEQ/BNE, other legal branch funct3 not taken.
MEM_TIMEOUT, 255, max cycles waiting for mem_ready before TRAP; 0 disables the timeout.
CNT_W, 32, width of retire_count.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
zero  in  1  ALU result == 0
lt  in  1  rs1 < rs2, signed (datapath comparator)
ltu  in  1  rs1 < rs2, unsigned
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects
ResultSrc, ALUSrcA, ALUSrcB, alu_op  out  2 each  datapath selects
trap  out  1  sticky; high while in TRAP
trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
state_o  out  4  current state, for debug
instr_retired  out  1  one-cycle pulse on the final cycle of each completed instruction
retire_count  out  CNT_W  count of retired instructions; wraps to 0

Behaviour:
- Encodings:
  - ALUSrcA: 00 PC, 01 oldPC, 10 rs1.
  - ALUSrcB: 00 rs2, 01 imm, 10 const 4.
  - ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
  - alu_op: 00 add, 01 subtract, 10 funct-decoded.
  - Default for all outputs is 0.
- Reset: while rst is low, state=FETCH(0), the timeout counter, retire_count and trap_cause are cleared, and all outputs are forced to 0. The first request is issued in the cycle after rst deasserts. An access interrupted by reset is abandoned.
- State encoding (4 bits):
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, MEM_WB=7
  - ALU_WB=8, JAL=9, JALR_ADDR=10, JALR_JUMP=11, BRANCH=12, LUI=13, AUIPC=14, TRAP=15.
- FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; that cycle moves to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR.
    - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 with funct3=000 -> JALR_ADDR.
    - 0110111 -> LUI; 0010111 -> AUIPC.
    - Anything else is illegal.
- EXEC_R: rs1 op rs2, alu_op=10, then ALU_WB.
- EXEC_I: rs1 op imm, alu_op=10, then ALU_WB.
- LUI: ALUSrcB=01, alu_op=10, then ALU_WB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, alu_op=10, then ALU_WB.
- MEM_ADDR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEM_WRITE for a store, MEM_READ for a load.
- MEM_READ: mem_req=1, AdrSrc=1, ResultSrc=00. Waits for mem_ready, then MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1; retires.
- MEM_WRITE: mem_req=1, AdrSrc=1, ResultSrc=00. MemWrite is held high until the mem_ready cycle; that cycle retires.
- ALU_WB: ResultSrc=00, RegWrite=1; retires.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALU_WB (link = oldPC+4).
- JALR_ADDR: ALUSrcA=10, ALUSrcB=01, add, then JALR_JUMP.
- JALR_JUMP: identical to JAL outputs, then ALU_WB.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, alu_op=01, ResultSrc=00.
  - PCWrite when taken. Taken condition by funct3:
    - 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - funct3 010/011 is illegal. Otherwise retires, then FETCH.
- Illegal instruction:
  - TRAP_ON_ILLEGAL=1: go to TRAP with trap_cause=01.
  - TRAP_ON_ILLEGAL=0: go to FETCH with no retire pulse.
- Timeout (wait states FETCH, MEM_READ, MEM_WRITE):
  - The counter clears on entry to each wait state and increments each cycle mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with trap_cause=10.
  - mem_ready arriving in the same cycle as the limit wins: the access completes normally.
- TRAP: all control outputs 0, trap=1; stays until reset.
- Retire: instr_retired is combinational (1 in the retiring cycle). retire_count increments on that clock edge and wraps from all-ones to 0.

Test Plan:
- ADD with mem_ready tied high -> FETCH, DECODE, EXEC_R, ALU_WB (4 cycles); RegWrite=1 only in ALU_WB; retire_count=1.
- LW with mem_ready delayed 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_req=1; MEM_WB asserts RegWrite, ResultSrc=01.
- BLT with lt=1 then lt=0; BGEU with ltu=0 -> PCWrite = 1, 0, 1 respectively. With ALL_BRANCHES=0, BLT lt=1 -> PCWrite=0.
- opcode 1111111 -> TRAP_ON_ILLEGAL=1: trap=1, trap_cause=01, state_o=15 held until rst low. TRAP_ON_ILLEGAL=0: back to FETCH, retire_count unchanged.
- MEM_TIMEOUT=4, store with mem_ready never asserted -> TRAP, cause=10. Re-run with mem_ready asserted exactly at the limit -> completes and retires.
- JALR -> JALR_ADDR, JALR_JUMP (PCWrite=1, ALUSrcA=01, ALUSrcB=10), then ALU_WB. rst pulsed mid-MEM_READ -> all outputs 0 immediately, FETCH after release. retire_count preloaded to all-ones wraps to 0.
